// File: rtl/imm_pipe.sv
// ---------------------------------------------------------------------------
// imm_pipe -- registered, handshaked immediate generator and target adder.
//
// Each accepted transfer (inst, pc, imm_ctrl) is decoded on the input side
// into an XLEN-wide extended immediate, pc + imm, and an illegal flag. The
// result is held in a two-entry elastic buffer (main = output entry, skid).
// Because in_ready comes from a flop, decode can stall without a
// combinational ready path.
//
// Parameters:
//   XLEN           datapath width, 32 or 64
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous drop of every buffered entry (wins over transfers)
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   inst, pc, imm_ctrl  instruction word, its address, format select
//                       (0 none, 1 I, 2 U, 3 S, 4 B, 5 J, 6 Z, 7 C)
//   out_valid/out_ready downstream handshake
//   imm, target, illegal  extended immediate, pc + imm, unsupported format
//
// Build option: define IMM_PIPE_RVC_EN to decode compressed immediates for
// imm_ctrl 7. Without it, imm_ctrl 7 reports illegal with imm 0.
// ---------------------------------------------------------------------------
module imm_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      imm_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    // ---------------- input-side decode ----------------
    // Every format fits in a signed 32-bit value; the size cast below
    // sign-extends it to XLEN (Z and unsigned RVC fields stay positive).
    logic signed [31:0] imm32;
    logic               ill_in;
    logic [XLEN-1:0]    imm_in;
    logic [XLEN-1:0]    target_in;

`ifdef IMM_PIPE_RVC_EN
    logic signed [31:0] rvc_imm32;
    logic               rvc_ill;
    logic [4:0]         rvc_op;

    assign rvc_op = {inst[1:0], inst[15:13]};

    always_comb begin
        rvc_imm32 = '0;
        rvc_ill   = 1'b0;
        case (rvc_op)
            5'b00_000: begin // C.ADDI4SPN nzuimm[9:2]
                rvc_imm32 = {22'b0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b00};
                rvc_ill   = (inst[12:5] == 8'd0);
            end
            5'b00_010, 5'b00_110: // C.LW / C.SW uimm[6:2]
                rvc_imm32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b00};
            5'b01_000, 5'b01_010: // C.ADDI / C.LI imm[5:0]
                rvc_imm32 = {{26{inst[12]}}, inst[12], inst[6:2]};
            5'b01_001, 5'b01_101: // C.JAL / C.J offset[11:1]
                rvc_imm32 = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6],
                             inst[7], inst[2], inst[11], inst[5:3], 1'b0};
            5'b01_011: begin
                // rd == x2 selects C.ADDI16SP, any other rd is C.LUI
                if (inst[11:7] == 5'd2) begin
                    rvc_imm32 = {{22{inst[12]}}, inst[12], inst[4:3], inst[5], inst[2],
                                 inst[6], 4'b0000};
                end else begin
                    rvc_imm32 = {{14{inst[12]}}, inst[12], inst[6:2], 12'b0};
                end
                rvc_ill = ({inst[12], inst[6:2]} == 6'd0);
            end
            5'b01_110, 5'b01_111: // C.BEQZ / C.BNEZ offset[8:1]
                rvc_imm32 = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                             inst[4:3], 1'b0};
            5'b10_010: // C.LWSP uimm[7:2]
                rvc_imm32 = {24'b0, inst[3:2], inst[12], inst[6:4], 2'b00};
            5'b10_110: // C.SWSP uimm[7:2]
                rvc_imm32 = {24'b0, inst[8:7], inst[12:9], 2'b00};
            default: begin
                rvc_imm32 = '0;
                rvc_ill   = 1'b1;
            end
        endcase
    end
`else
    // Opcode bits are not needed by any uncompressed format.
    logic unused_inst;
    assign unused_inst = ^inst[6:0];
`endif

    always_comb begin
        imm32  = '0;
        ill_in = 1'b0;
        case (imm_ctrl)
            3'd1: imm32 = {{20{inst[31]}}, inst[31:20]};
            3'd2: imm32 = {inst[31:12], 12'b0};
            3'd3: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            3'd4: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            3'd5: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            3'd6: imm32 = {27'b0, inst[19:15]};
            3'd7: begin
`ifdef IMM_PIPE_RVC_EN
                imm32  = rvc_imm32;
                ill_in = rvc_ill;
`else
                ill_in = 1'b1;
`endif
            end
            default: imm32 = '0;
        endcase
    end

    assign imm_in    = XLEN'(imm32);
    assign target_in = pc + imm_in;

    // ---------------- two-entry elastic buffer ----------------
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            illegal_q, illegal_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [XLEN-1:0] skid_target_q, skid_target_d;
    logic            skid_illegal_q, skid_illegal_d;
    logic            in_ready_q, in_ready_d;

    logic accept;
    logic drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        out_valid_d    = out_valid_q;
        imm_d          = imm_q;
        target_d       = target_q;
        illegal_d      = illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_target_d  = skid_target_q;
        skid_illegal_d = skid_illegal_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                // Oldest entry lives in skid: promote it, new input backfills skid.
                out_valid_d    = 1'b1;
                imm_d          = skid_imm_q;
                target_d       = skid_target_q;
                illegal_d      = skid_illegal_q;
                skid_valid_d   = accept;
                if (accept) begin
                    skid_imm_d     = imm_in;
                    skid_target_d  = target_in;
                    skid_illegal_d = ill_in;
                end
            end else begin
                // Data fields load only on a real transfer so outputs stay put.
                out_valid_d = accept;
                if (accept) begin
                    imm_d     = imm_in;
                    target_d  = target_in;
                    illegal_d = ill_in;
                end
            end
        end else if (accept) begin
            skid_valid_d   = 1'b1;
            skid_imm_d     = imm_in;
            skid_target_d  = target_in;
            skid_illegal_d = ill_in;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            imm_q          <= '0;
            target_q       <= '0;
            illegal_q      <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_target_q  <= '0;
            skid_illegal_q <= 1'b0;
            in_ready_q     <= 1'b1;
        end else begin
            out_valid_q    <= out_valid_d;
            imm_q          <= imm_d;
            target_q       <= target_d;
            illegal_q      <= illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_target_q  <= skid_target_d;
            skid_illegal_q <= skid_illegal_d;
            in_ready_q     <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign imm       = imm_q;
    assign target    = target_q;
    assign illegal   = illegal_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_imm_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_pipe -- directed self-checking bench for imm_pipe.
// An XLEN=32 instance carries most checks; an XLEN=64 instance shares the
// same stimulus and is checked on the U-format sign extension.
// ---------------------------------------------------------------------------
module tb_imm_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic [63:0] pc64;
    logic [2:0]  imm_ctrl = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, illegal;
    logic [31:0] imm, target;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64, target64;

    int n_chk = 0;
    int n_err = 0;

    assign pc64 = {32'h0, pc};

    always #5 clk = ~clk;

    imm_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .imm_ctrl(imm_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .target(target), .illegal(illegal)
    );

    imm_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .pc(pc64), .imm_ctrl(imm_ctrl),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .target(target64), .illegal(illegal64)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic [2:0] c, input logic r, input logic f);
        in_valid  = v;
        inst      = i;
        pc        = p;
        imm_ctrl  = c;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer with out_ready high; checks the 1-cycle result.
    task automatic single(input string tag, input logic [31:0] i, input logic [31:0] p,
                          input logic [2:0] c, input logic [31:0] e_imm,
                          input logic [31:0] e_tgt, input logic e_ill);
        step(1'b1, i, p, c, 1'b1, 1'b0);
        $display("txn %s: inst=0x%08h pc=0x%0h ctrl=%0d -> imm=0x%0h target=0x%0h illegal=%0b",
                 tag, i, p, c, imm, target, illegal);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, ".imm"}, 64'(imm), 64'(e_imm));
        check_eq({tag, ".target"}, 64'(target), 64'(e_tgt));
        check_eq({tag, ".illegal"}, 64'(illegal), 64'(e_ill));
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);
        check_eq({tag, ".drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.out_valid", 64'(out_valid), 64'd0);
        check_eq("rst.in_ready", 64'(in_ready), 64'd1);
        check_eq("rst.imm", 64'(imm), 64'd0);
        check_eq("rst.target", 64'(target), 64'd0);
        check_eq("rst.illegal", 64'(illegal), 64'd0);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

        // ---------------- formats ----------------
        single("I",    32'hFFF00093, 32'h100, 3'd1, 32'hFFFFFFFF, 32'h000000FF, 1'b0);
        single("B",    32'h00000463, 32'h200, 3'd4, 32'h00000008, 32'h00000208, 1'b0);
        single("J",    32'hFFDFF06F, 32'h300, 3'd5, 32'hFFFFFFFC, 32'h000002FC, 1'b0);
        single("S",    32'hFE002E23, 32'h400, 3'd3, 32'hFFFFFFFC, 32'h000003FC, 1'b0);
        single("Z",    32'h000FD073, 32'h020, 3'd6, 32'h0000001F, 32'h0000003F, 1'b0);
        single("NONE", 32'hFFF00093, 32'h040, 3'd0, 32'h00000000, 32'h00000040, 1'b0);
        single("U",    32'h123450B7, 32'h010, 3'd2, 32'h12345000, 32'h12345010, 1'b0);
        single("C0",   32'h00000000, 32'h600, 3'd7, 32'h00000000, 32'h00000600, 1'b1);
`ifdef IMM_PIPE_RVC_EN
        single("CLI",  32'h000050FD, 32'h500, 3'd7, 32'hFFFFFFFF, 32'h000004FF, 1'b0);
`else
        single("CLI",  32'h000050FD, 32'h500, 3'd7, 32'h00000000, 32'h00000500, 1'b1);
`endif

        // ---------------- XLEN=64 U sign extension ----------------
        step(1'b1, 32'h800000B7, 32'h100, 3'd2, 1'b1, 1'b0);
        $display("txn U64: imm64=0x%0h target64=0x%0h imm32=0x%0h", imm64, target64, imm);
        check_eq("U64.valid", 64'(out_valid64), 64'd1);
        check_eq("U64.imm", imm64, 64'hFFFFFFFF80000000);
        check_eq("U64.target", target64, 64'hFFFFFFFF80000100);
        check_eq("U32.imm", 64'(imm), 64'h80000000);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

        // ---------------- backpressure ----------------
        check_eq("bp.ready0", 64'(in_ready), 64'd1);
        step(1'b1, 32'h00100093, 32'h1000, 3'd1, 1'b0, 1'b0); // A accepted
        $display("txn bp1: out_valid=%0b imm=0x%0h in_ready=%0b", out_valid, imm, in_ready);
        check_eq("bp1.valid", 64'(out_valid), 64'd1);
        check_eq("bp1.imm", 64'(imm), 64'd1);
        check_eq("bp1.target", 64'(target), 64'h1001);
        check_eq("bp1.ready", 64'(in_ready), 64'd1);
        step(1'b1, 32'h00200093, 32'h1004, 3'd1, 1'b0, 1'b0); // B into skid
        $display("txn bp2: out_valid=%0b imm=0x%0h in_ready=%0b", out_valid, imm, in_ready);
        check_eq("bp2.ready", 64'(in_ready), 64'd0);
        check_eq("bp2.hold_imm", 64'(imm), 64'd1);
        step(1'b1, 32'h00300093, 32'h1008, 3'd1, 1'b0, 1'b0); // C refused
        $display("txn bp3: out_valid=%0b imm=0x%0h in_ready=%0b", out_valid, imm, in_ready);
        check_eq("bp3.ready", 64'(in_ready), 64'd0);
        check_eq("bp3.hold_target", 64'(target), 64'h1001);
        step(1'b1, 32'h00300093, 32'h1008, 3'd1, 1'b1, 1'b0); // A drains, B to main
        $display("txn bp4: out_valid=%0b imm=0x%0h in_ready=%0b", out_valid, imm, in_ready);
        check_eq("bp4.valid", 64'(out_valid), 64'd1);
        check_eq("bp4.imm", 64'(imm), 64'd2);
        check_eq("bp4.target", 64'(target), 64'h1006);
        check_eq("bp4.ready", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0); // only now C could enter
        $display("txn bp5: out_valid=%0b imm=0x%0h in_ready=%0b", out_valid, imm, in_ready);
        check_eq("bp5.valid", 64'(out_valid), 64'd0);
        check_eq("bp5.imm_hold", 64'(imm), 64'd2);
        step(1'b1, 32'h00300093, 32'h1008, 3'd1, 1'b1, 1'b0); // C accepted
        $display("txn bp6: out_valid=%0b imm=0x%0h in_ready=%0b", out_valid, imm, in_ready);
        check_eq("bp6.valid", 64'(out_valid), 64'd1);
        check_eq("bp6.imm", 64'(imm), 64'd3);
        check_eq("bp6.target", 64'(target), 64'h100B);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);
        check_eq("bp7.empty", 64'(out_valid), 64'd0);

        // ---------------- flush with both entries full ----------------
        step(1'b1, 32'h00400093, 32'h2000, 3'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00500093, 32'h2004, 3'd1, 1'b0, 1'b0);
        check_eq("fl.full", 64'(in_ready), 64'd0);
        step(1'b1, 32'h00600093, 32'h2008, 3'd1, 1'b0, 1'b1);
        $display("txn flush_full: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        check_eq("fl.valid", 64'(out_valid), 64'd0);
        check_eq("fl.ready", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);
        check_eq("fl.no_ghost", 64'(out_valid), 64'd0);

        // flush while ready: the presented input must be discarded
        step(1'b1, 32'h00700093, 32'h3000, 3'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00800093, 32'h3004, 3'd1, 1'b0, 1'b1);
        $display("txn flush_ready: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        check_eq("fl2.valid", 64'(out_valid), 64'd0);
        step(1'b1, 32'h00900093, 32'h3008, 3'd1, 1'b1, 1'b0);
        check_eq("fl2.next_imm", 64'(imm), 64'd9);
        check_eq("fl2.next_target", 64'(target), 64'h3011);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

        // ---------------- asynchronous reset mid-stream ----------------
        step(1'b1, 32'h00A00093, 32'h4000, 3'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00B00093, 32'h4004, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        $display("txn async_rst: out_valid=%0b in_ready=%0b imm=0x%0h", out_valid, in_ready, imm);
        check_eq("arst.valid", 64'(out_valid), 64'd0);
        check_eq("arst.ready", 64'(in_ready), 64'd1);
        check_eq("arst.imm", 64'(imm), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);
        check_eq("arst.after", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
